sr_cmd_sequencer: RTL and testbench

Front-end stage that feeds the `sr_latch`. It synchronizes and debounces two raw push-button inputs, converts each debounced press into a set or clear command, and drives the latch's `s`, `r` and `enable` inputs with clean, non-overlapping, fixed-width pulses. It sits between the board buttons and the latch. It guarantees the latch never sees `s` and `r` asserted together and never sees a command change while `enable` is high.

---
 rtl/sr_cmd_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_sr_cmd_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_cmd_sequencer.sv
// sr_cmd_sequencer: button front end for sr_latch.
// Syncs and debounces two buttons, then issues clean s/r/enable pulses.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a debounced level flips (1..255)
//   HOLD_CYCLES      cycles enable and s/r stay high per command (1..255)
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   btn_set  raw asynchronous set button
//   btn_clr  raw asynchronous clear button
//   s        set command to latch
//   r        reset command to latch
//   enable   latch enable, high only with s or r
//   busy     sequencer not idle
//   deb_set  debounced btn_set level
//   deb_clr  debounced btn_clr level
//   req_ovf  sticky: a command was dropped
module sr_cmd_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_clr,
  output logic s,
  output logic r,
  output logic enable,
  output logic busy,
  output logic deb_set,
  output logic deb_clr,
  output logic req_ovf
);

  localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE_S,
    DRIVE_R,
    GAP
  } state_t;

  // Index 0 is the set path, index 1 is the clear path.
  logic [1:0] btn;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] deb_q;
  logic [1:0] deb_d;
  logic [1:0] deb_dly_q;
  logic [7:0] cnt_q [2];
  logic [7:0] cnt_d [2];
  logic [1:0] req;

  state_t     state_q;
  state_t     state_d;
  logic [7:0] hold_q;
  logic [7:0] hold_d;
  logic       pend_s_q;
  logic       pend_s_d;
  logic       pend_r_q;
  logic       pend_r_d;
  logic       ovf_q;
  logic       ovf_d;

  logic       s_q;
  logic       r_q;
  logic       en_q;
  logic       busy_q;

  logic       req_s;
  logic       req_r;
  logic       cand_s;
  logic       cand_r;
  logic       can_serve;
  logic       serve_s;
  logic       serve_r;

  assign btn = {btn_clr, btn_set};

  // Debounce: the level flips only after the synced input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = 8'd0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Rising edges of the debounced levels only.
  assign req   = deb_q & ~deb_dly_q;
  assign req_s = req[0];
  assign req_r = req[1];

  assign cand_r = req_r | pend_r_q;
  assign cand_s = req_s | pend_s_q;

  assign can_serve = (state_q == IDLE) || (state_q == GAP);
  assign serve_r   = can_serve & cand_r;
  assign serve_s   = can_serve & ~cand_r & cand_s;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (cand_r) begin
          state_d = DRIVE_R;
          hold_d  = 8'd0;
        end else if (cand_s) begin
          state_d = DRIVE_S;
          hold_d  = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (hold_q == HOLD_LAST) begin
          state_d = GAP;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
    endcase
  end

  // Pending bits: serving consumes one command; if a fresh request
  // and a pending one coincide on a serve, the fresh one stays queued.
  // A request that finds its pending bit already set is dropped.
  always_comb begin
    pend_s_d = pend_s_q;
    pend_r_d = pend_r_q;
    ovf_d    = ovf_q;
    if (serve_r) begin
      pend_r_d = pend_r_q & req_r;
    end else if (req_r) begin
      pend_r_d = 1'b1;
      if (pend_r_q) begin
        ovf_d = 1'b1;
      end
    end
    if (serve_s) begin
      pend_s_d = pend_s_q & req_s;
    end else if (req_s) begin
      pend_s_d = 1'b1;
      if (pend_s_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      deb_q     <= 2'b00;
      deb_dly_q <= 2'b00;
      cnt_q[0]  <= 8'd0;
      cnt_q[1]  <= 8'd0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
    end
  end

  // Outputs are registered from the next state so they change
  // cleanly on the clock edge together with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_q   <= 8'd0;
      pend_s_q <= 1'b0;
      pend_r_q <= 1'b0;
      ovf_q    <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      pend_s_q <= pend_s_d;
      pend_r_q <= pend_r_d;
      ovf_q    <= ovf_d;
      s_q      <= (state_d == DRIVE_S);
      r_q      <= (state_d == DRIVE_R);
      en_q     <= (state_d == DRIVE_S) ||
                  (state_d == DRIVE_R);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign s       = s_q;
  assign r       = r_q;
  assign enable  = en_q;
  assign busy    = busy_q;
  assign deb_set = deb_q[0];
  assign deb_clr = deb_q[1];
  assign req_ovf = ovf_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb_sr_cmd_sequencer: directed bench for sr_cmd_sequencer.
// Default instance plus a long-hold instance for the drop case.
module tb_sr_cmd_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bs = 1'b0;
  logic bc = 1'b0;
  logic bs2 = 1'b0;
  logic bc2 = 1'b0;

  logic s1, r1, en1, busy1, ds1, dc1, ovf1;
  logic s2, r2, en2, busy2, ds2, dc2, ovf2;

  int n_assert = 0;
  int n_fail = 0;

  int sc, rc, rise, rise_r;
  logic prev, prev_r, acc, acc2;

  always #5 clk = ~clk;

  sr_cmd_sequencer dut (
    .clk(clk), .reset(reset),
    .btn_set(bs), .btn_clr(bc),
    .s(s1), .r(r1), .enable(en1),
    .busy(busy1), .deb_set(ds1),
    .deb_clr(dc1), .req_ovf(ovf1)
  );

  sr_cmd_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(40)
  ) dut2 (
    .clk(clk), .reset(reset),
    .btn_set(bs2), .btn_clr(bc2),
    .s(s2), .r(r2), .enable(en2),
    .busy(busy2), .deb_set(ds2),
    .deb_clr(dc2), .req_ovf(ovf2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs1();
    return {s1, r1, en1, busy1, ds1, dc1, ovf1};
  endfunction

  always @(negedge clk) begin
    n_assert++;
    assert (((s1 & r1) === 1'b0) &&
            (en1 === (s1 ^ r1)) &&
            ((s2 & r2) === 1'b0) &&
            (en2 === (s2 ^ r2))) else begin
      n_fail++;
      $error("FAIL overlap: observed s/r/en %b%b%b %b%b%b expected exclusive",
             s1, r1, en1, s2, r2, en2);
    end
  end

  initial begin
    // reset held three edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outs", 32'(outs1()), 0);
      chk("reset_outs2", 32'({s2, r2, en2, busy2, ovf2}), 0);
    end
    reset = 1'b0;
    repeat (5) step();
    chk("idle_outs", 32'(outs1()), 0);

    // clean set press
    bs = 1'b1;
    sc = 0; rc = 0; rise = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 4) chk("press_deb_pre", 32'(ds1), 0);
      if (i == 5) begin
        chk("press_deb", 32'(ds1), 1);
        chk("press_s_pre", 32'(s1), 0);
      end
      if (i == 6) chk("press_drive", 32'({s1, en1, busy1, r1}), 32'b1110);
      if (i == 7) chk("press_hold", 32'({s1, en1}), 32'b11);
      if (i == 8) chk("press_gap", 32'({s1, en1, busy1}), 32'b001);
      if (i == 9) chk("press_idle", 32'(busy1), 0);
      if (s1 && !prev) rise++;
      if (s1) sc++;
      if (r1) rc++;
      prev = s1;
      if (i == 19) bs = 1'b0;
    end
    chk("press_s_cycles", sc, 2);
    chk("press_s_pulses", rise, 1);
    chk("press_no_r", rc, 0);

    // 3-cycle glitch
    acc = 1'b0; acc2 = 1'b0;
    bs = 1'b1;
    repeat (3) step();
    bs = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      acc = acc | ds1;
      acc2 = acc2 | s1;
    end
    chk("glitch_deb", 32'(acc), 0);
    chk("glitch_s", 32'(acc2), 0);

    // simultaneous press: clear first, then set
    bs = 1'b1; bc = 1'b1;
    sc = 0; rc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 6) chk("sim_r1", 32'({s1, r1, en1, busy1}), 32'b0111);
      if (i == 7) chk("sim_r2", 32'({s1, r1, en1, busy1}), 32'b0111);
      if (i == 8) chk("sim_gap", 32'({s1, r1, en1, busy1}), 32'b0001);
      if (i == 9) chk("sim_s1", 32'({s1, r1, en1, busy1}), 32'b1011);
      if (i == 10) chk("sim_s2", 32'({s1, r1, en1, busy1}), 32'b1011);
      if (i == 11) chk("sim_gap2", 32'({s1, r1, en1, busy1}), 32'b0001);
      if (i == 12) chk("sim_idle", 32'({s1, r1, en1, busy1}), 32'b0000);
      if (s1) sc++;
      if (r1) rc++;
      if (i == 19) begin
        bs = 1'b0; bc = 1'b0;
      end
    end
    chk("sim_s_cycles", sc, 2);
    chk("sim_r_cycles", rc, 2);
    chk("sim_ovf", 32'(ovf1), 0);

    // reset during DRIVE_R with set pending: nothing survives
    bs = 1'b1; bc = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 6) chk("rmid_r", 32'(r1), 1);
    end
    reset = 1'b1; bs = 1'b0; bc = 1'b0;
    step();
    chk("rmid_outs", 32'(outs1()), 0);
    reset = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc = acc | s1 | r1 | busy1;
    end
    chk("rmid_no_cmd", 32'(acc), 0);

    // reset on first DRIVE_S cycle, button held through
    bs = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 6) chk("rds_s", 32'(s1), 1);
    end
    reset = 1'b1;
    step();
    chk("rds_outs", 32'(outs1()), 0);
    reset = 1'b0;
    rise = 0; prev = 1'b0;
    for (int j = 1; j <= 30; j++) begin
      step();
      if (j == 6) chk("rds_deb", 32'({ds1, s1}), 32'b10);
      if (j == 7) chk("rds_drive", 32'({s1, en1}), 32'b11);
      if (j == 8) chk("rds_hold", 32'({s1, en1}), 32'b11);
      if (j == 9) chk("rds_gap", 32'(s1), 0);
      if (s1 && !prev) rise++;
      prev = s1;
      if (j == 12) bs = 1'b0;
    end
    chk("rds_pulses", rise, 1);

    // drop: two set presses during one long DRIVE_R
    bc2 = 1'b1;
    rise = 0; rise_r = 0; prev = 1'b0; prev_r = 1'b0;
    for (int i = 0; i < 120; i++) begin
      step();
      if (i == 6) begin
        chk("ovf_r_start", 32'(r2), 1);
        bs2 = 1'b1;
      end
      if (i == 15) bs2 = 1'b0;
      if (i == 19) bc2 = 1'b0;
      if (i == 25) bs2 = 1'b1;
      if (i == 31) chk("ovf_pre", 32'(ovf2), 0);
      if (i == 32) chk("ovf_set", 32'(ovf2), 1);
      if (i == 35) bs2 = 1'b0;
      if (i == 45) chk("ovf_r_end", 32'({s2, r2}), 32'b01);
      if (i == 46) chk("ovf_gap", 32'({s2, r2, en2, busy2}), 32'b0001);
      if (i == 47) chk("ovf_s", 32'({s2, r2, en2}), 32'b101);
      if (i == 88) chk("ovf_idle", 32'(busy2), 0);
      if (s2 && !prev) rise++;
      if (r2 && !prev_r) rise_r++;
      prev = s2;
      prev_r = r2;
    end
    chk("ovf_s_pulses", rise, 1);
    chk("ovf_r_pulses", rise_r, 1);
    chk("ovf_sticky", 32'(ovf2), 1);
    reset = 1'b1;
    step();
    chk("ovf_reset", 32'(ovf2), 0);
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
